pc_fetch_stage: RTL and testbench

- Program-counter register and IF/ID pipeline register for the 64-bit LEGv8 core.
- Drives the current PC to the PC+4 incrementer and to instruction memory, and consumes the incrementer's sum.
- Selects the next PC from PC+4, a branch target, or a redirect held over a stall.
- Registers the fetched instruction and its PC, with a valid bit, for decode.

---
 rtl/pc_fetch_if.sv | 28 ++
 rtl/pc_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: PC out to the incrementer and instruction memory, redirect/hazard controls in,
// and the IF/ID register contents out to decode.
interface pc_fetch_if;
    // if_valid marks a real instruction in IF/ID; stall freezes IF/ID, so decode may sample the same
    // valid instruction over several cycles, and flush or a redirect turns the slot into a bubble.
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        br_taken;
    logic [63:0] br_target;
    logic        stall;
    logic        flush;
    logic [31:0] instr_in;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        redirect_pending;
    logic        misalign_err;

    modport master (
        input  pc, if_pc, if_instr, if_valid, redirect_pending, misalign_err,
        output pc_plus4, br_taken, br_target, stall, flush, instr_in
    );

    modport slave (
        output pc, if_pc, if_instr, if_valid, redirect_pending, misalign_err,
        input  pc_plus4, br_taken, br_target, stall, flush, instr_in
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// LEGv8 fetch stage: PC register with branch/stall redirect logic and the IF/ID pipeline register.
// A redirect that arrives during a stall is parked in a pending register until the stall lifts.
module pc_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned WARMUP   = 1
) (
    input  logic         clk,
    input  logic         reset,
    pc_fetch_if.slave    bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [3:0] WARMUP_LAST = 4'(WARMUP - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] pend_q, pend_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic        rp_q, rp_d;
    logic        mis_q, mis_d;
    logic [63:0] tgt_aligned;
    logic        tgt_misaligned;

    assign tgt_aligned    = {bus.br_target[63:2], 2'b00};
    assign tgt_misaligned = bus.br_taken && (bus.br_target[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        mis_d      = mis_q;

        case (state_q)
            BOOT: begin
                // Instruction memory needs WARMUP cycles before its first read data is usable.
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WARMUP_LAST) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (tgt_misaligned) begin
                    mis_d = 1'b1;
                end
                if (bus.stall) begin
                    if (bus.br_taken) begin
                        pend_d  = tgt_aligned;
                        state_d = HOLD;
                    end
                    if (bus.flush) begin
                        if_valid_d = 1'b0;
                    end
                end else if (bus.br_taken) begin
                    pc_d       = tgt_aligned;
                    if_valid_d = 1'b0;
                end else begin
                    pc_d = bus.pc_plus4;
                    if (bus.flush) begin
                        if_valid_d = 1'b0;
                    end else begin
                        if_pc_d    = pc_q;
                        if_instr_d = bus.instr_in;
                        if_valid_d = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (tgt_misaligned) begin
                    mis_d = 1'b1;
                end
                if (bus.stall) begin
                    // Newest redirect wins while the stall persists.
                    if (bus.br_taken) begin
                        pend_d = tgt_aligned;
                    end
                    if (bus.flush) begin
                        if_valid_d = 1'b0;
                    end
                end else begin
                    pc_d       = bus.br_taken ? tgt_aligned : pend_q;
                    if_valid_d = 1'b0;
                    state_d    = RUN;
                end
            end

            default: begin
                state_d = BOOT;
                cnt_d   = 4'd0;
            end
        endcase

        rp_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            cnt_q      <= 4'd0;
            pc_q       <= RESET_PC;
            pend_q     <= 64'h0;
            if_pc_q    <= 64'h0;
            if_instr_q <= 32'h0;
            if_valid_q <= 1'b0;
            rp_q       <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            rp_q       <= rp_d;
            mis_q      <= mis_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.if_pc            = if_pc_q;
    assign bus.if_instr         = if_instr_q;
    assign bus.if_valid         = if_valid_q;
    assign bus.redirect_pending = rp_q;
    assign bus.misalign_err     = mis_q;
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed walk through fetch, branch, stalled redirect, misalignment,
// wrap-around and reset-in-HOLD, then random traffic, all compared to a behavioural model.
module tb_pc_fetch_stage;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          WARMUP   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dbg_state;

    pc_fetch_if bus ();

    pc_fetch_stage #(
        .RESET_PC (RESET_PC),
        .WARMUP   (WARMUP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Environment: PC+4 incrementer and an instruction memory that returns the low word of the address.
    assign bus.pc_plus4 = bus.pc + 64'd4;
    assign bus.instr_in = bus.pc[31:0];

    int n_evals = 0;
    int n_fails = 0;

    // Behavioural model of the fetch stage.
    logic [63:0] m_pc, m_if_pc, m_pend;
    logic [31:0] m_if_instr;
    logic        m_if_valid, m_pend_valid, m_mis;
    int          m_boot_left;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_evals++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all();
        check("pc", bus.pc, m_pc);
        check("if_pc", bus.if_pc, m_if_pc);
        check("if_instr", 64'(bus.if_instr), 64'(m_if_instr));
        check("if_valid", 64'(bus.if_valid), 64'(m_if_valid));
        check("redirect_pending", 64'(bus.redirect_pending), 64'(m_pend_valid));
        check("misalign_err", 64'(bus.misalign_err), 64'(m_mis));
    endtask

    task automatic model_reset();
        m_pc         = RESET_PC;
        m_if_pc      = 64'h0;
        m_if_instr   = 32'h0;
        m_if_valid   = 1'b0;
        m_pend       = 64'h0;
        m_pend_valid = 1'b0;
        m_mis        = 1'b0;
        m_boot_left  = WARMUP;
    endtask

    task automatic model_step();
        logic [63:0] tgt;
        tgt = bus.br_target & ~64'h3;
        if (m_boot_left > 0) begin
            m_boot_left--;
        end else begin
            if (bus.br_taken && bus.br_target[1:0] != 2'b00) m_mis = 1'b1;
            if (bus.stall) begin
                if (bus.br_taken) begin
                    m_pend       = tgt;
                    m_pend_valid = 1'b1;
                end
                if (bus.flush) m_if_valid = 1'b0;
            end else if (m_pend_valid) begin
                m_pc         = bus.br_taken ? tgt : m_pend;
                m_if_valid   = 1'b0;
                m_pend_valid = 1'b0;
            end else if (bus.br_taken) begin
                m_pc       = tgt;
                m_if_valid = 1'b0;
            end else begin
                if (bus.flush) begin
                    m_if_valid = 1'b0;
                end else begin
                    m_if_pc    = m_pc;
                    m_if_instr = m_pc[31:0];
                    m_if_valid = 1'b1;
                end
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic set_in(input logic br, input logic [63:0] tgt, input logic st, input logic fl);
        bus.br_taken  = br;
        bus.br_target = tgt;
        bus.stall     = st;
        bus.flush     = fl;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] tgt;
        set_in(1'b0, 64'h0, 1'b0, 1'b0);
        #3;
        do_reset();
        check("reset_pc", bus.pc, 64'h0);
        check("reset_valid", 64'(bus.if_valid), 64'h0);

        // Warm-up, then sequential fetch 0,4,8.
        cycle();
        cycle();
        check("boot_pc", bus.pc, 64'h0);
        check("boot_valid", 64'(bus.if_valid), 64'h0);
        cycle();
        check("first_if_pc", bus.if_pc, 64'h0);
        check("first_valid", 64'(bus.if_valid), 64'h1);
        cycle();
        check("seq_pc", bus.pc, 64'h8);
        check("seq_if_instr", 64'(bus.if_instr), 64'h4);

        // Plain branch at pc=8.
        set_in(1'b1, 64'h100, 1'b0, 1'b0);
        cycle();
        check("br_pc", bus.pc, 64'h100);
        check("br_bubble", 64'(bus.if_valid), 64'h0);
        set_in(1'b0, 64'h0, 1'b0, 1'b0);
        cycle();
        check("br_if_pc", bus.if_pc, 64'h100);

        // Redirect arriving mid-stall at pc=0x20.
        set_in(1'b1, 64'h20, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 64'h0, 1'b1, 1'b0);
        cycle();
        set_in(1'b1, 64'h400, 1'b1, 1'b0);
        cycle();
        check("hold_pending", 64'(bus.redirect_pending), 64'h1);
        check("hold_pc", bus.pc, 64'h20);
        set_in(1'b0, 64'h0, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, 64'h0, 1'b0, 1'b0);
        cycle();
        check("redir_pc", bus.pc, 64'h400);
        check("redir_bubble", 64'(bus.if_valid), 64'h0);
        cycle();
        check("redir_if_pc", bus.if_pc, 64'h400);

        // Misaligned target and stickiness.
        set_in(1'b1, 64'h203, 1'b0, 1'b0);
        cycle();
        check("mis_pc", bus.pc, 64'h200);
        check("mis_set", 64'(bus.misalign_err), 64'h1);
        set_in(1'b1, 64'h300, 1'b0, 1'b0);
        cycle();
        check("mis_sticky", 64'(bus.misalign_err), 64'h1);

        // Wrap-around, then flush while advancing, then flush during stall.
        set_in(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 64'h0, 1'b0, 1'b0);
        cycle();
        check("wrap_pc", bus.pc, 64'h0);
        check("wrap_mis", 64'(bus.misalign_err), 64'h1);
        cycle();
        set_in(1'b0, 64'h0, 1'b0, 1'b1);
        cycle();
        check("flush_pc", bus.pc, 64'h8);
        check("flush_valid", 64'(bus.if_valid), 64'h0);
        set_in(1'b0, 64'h0, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 64'h0, 1'b1, 1'b1);
        cycle();
        check("stall_flush_valid", 64'(bus.if_valid), 64'h0);
        set_in(1'b0, 64'h0, 1'b0, 1'b0);
        cycle();

        // Reset while a redirect to 0x800 is pending.
        set_in(1'b1, 64'h800, 1'b1, 1'b0);
        cycle();
        check("pre_reset_pending", 64'(bus.redirect_pending), 64'h1);
        set_in(1'b0, 64'h0, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, 64'h0, 1'b0, 1'b0);
        do_reset();
        check("rst_pending", 64'(bus.redirect_pending), 64'h0);
        check("rst_mis", 64'(bus.misalign_err), 64'h0);
        for (int i = 0; i < WARMUP + 4; i++) begin
            cycle();
            check("never_800", 64'(bus.pc == 64'h800), 64'h0);
        end
        check("restart_pc", bus.pc, 64'h10);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                set_in(1'b0, 64'h0, 1'b0, 1'b0);
                do_reset();
            end else begin
                tgt = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
                set_in($urandom_range(0, 7) == 0, tgt, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_evals, n_fails);
        $finish;
    end

endmodule
